// File: rtl/countdown_scheduler_if.sv
// Bundle between the per-unit control FSMs (master) and the shared
// countdown scheduler (slave).
interface countdown_scheduler_if #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_REQ    = 4,
   parameter int IDX_WIDTH  = 2
);
   logic [NUM_REQ-1:0]            req;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_len;
   logic                          tick;
   logic [NUM_REQ-1:0]            grant;
   logic                          busy;
   logic [NUM_REQ-1:0]            done;
   logic [IDX_WIDTH-1:0]          owner;
   logic [DATA_WIDTH-1:0]         count;

   modport master (
      output req, req_len, tick,
      input  grant, busy, done, owner, count
   );

   modport slave (
      input  req, req_len, tick,
      output grant, busy, done, owner, count
   );
endinterface

// File: rtl/countdown_scheduler.sv
// One down-counter shared round-robin among NUM_REQ requesters; the owner's
// done bit pulses for one cycle when its count reaches zero.
module countdown_scheduler #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_REQ    = 4,
   parameter int IDX_WIDTH  = 2
) (
   input logic                  clock,
   input logic                  reset,
   countdown_scheduler_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [NUM_REQ-1:0]    NO_REQ   = {NUM_REQ{1'b0}};
   localparam logic [DATA_WIDTH-1:0] ZERO_CNT = {DATA_WIDTH{1'b0}};
   localparam logic [DATA_WIDTH-1:0] ONE_CNT  = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [IDX_WIDTH-1:0]  ZERO_IDX = {IDX_WIDTH{1'b0}};
   localparam logic [IDX_WIDTH-1:0]  LAST_IDX = IDX_WIDTH'(NUM_REQ - 1);

   state_t                state_r, state_s;
   logic [NUM_REQ-1:0]    grant_r, grant_s;
   logic [NUM_REQ-1:0]    done_r, done_s;
   logic                  busy_r, busy_s;
   logic [IDX_WIDTH-1:0]  owner_r, owner_s;
   logic [IDX_WIDTH-1:0]  last_owner_r, last_owner_s;
   logic [DATA_WIDTH-1:0] count_r, count_s;
   logic [IDX_WIDTH-1:0]  win_idx_s, cand_s;
   logic [DATA_WIDTH-1:0] win_len_s;
   logic                  any_req_s;

   function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_WIDTH-1:0] idx);
      logic [NUM_REQ-1:0] vec;
      vec      = NO_REQ;
      vec[idx] = 1'b1;
      return vec;
   endfunction

   // Round-robin pick: scanning offsets high to low leaves the nearest requester above last_owner_r.
   always_comb begin
      any_req_s = |bus.req;
      win_idx_s = last_owner_r;
      cand_s    = ZERO_IDX;
      for (int i = NUM_REQ; i >= 1; i--) begin
         cand_s    = IDX_WIDTH'((int'(last_owner_r) + i) % NUM_REQ);
         win_idx_s = bus.req[cand_s] ? cand_s : win_idx_s;
      end
      win_len_s = bus.req_len[int'(win_idx_s) * DATA_WIDTH +: DATA_WIDTH];
   end

   // Next-state and next-output logic; done is a pulse so it defaults low.
   always_comb begin
      state_s      = state_r;
      grant_s      = grant_r;
      done_s       = NO_REQ;
      busy_s       = busy_r;
      owner_s      = owner_r;
      last_owner_s = last_owner_r;
      count_s      = count_r;
      case (state_r)
         IDLE: begin
            if (any_req_s) begin
               owner_s = win_idx_s;
               if (win_len_s != ZERO_CNT) begin
                  state_s = RUN;
                  grant_s = onehot(win_idx_s);
                  busy_s  = 1'b1;
                  count_s = win_len_s;
               end else begin
                  state_s = DONE;
                  done_s  = onehot(win_idx_s);
               end
            end else begin
               state_s = IDLE;
            end
         end
         RUN: begin
            // Owner abort outranks a tick on the same edge, including the final one.
            if (!bus.req[owner_r]) begin
               state_s      = IDLE;
               grant_s      = NO_REQ;
               busy_s       = 1'b0;
               count_s      = ZERO_CNT;
               last_owner_s = owner_r;
            end else if (bus.tick) begin
               if (count_r <= ONE_CNT) begin
                  state_s = DONE;
                  grant_s = NO_REQ;
                  busy_s  = 1'b0;
                  count_s = ZERO_CNT;
                  done_s  = onehot(owner_r);
               end else begin
                  count_s = count_r - ONE_CNT;
               end
            end else begin
               count_s = count_r;
            end
         end
         DONE: begin
            state_s      = IDLE;
            grant_s      = NO_REQ;
            busy_s       = 1'b0;
            count_s      = ZERO_CNT;
            last_owner_s = owner_r;
         end
         default: begin
            state_s = IDLE;
            grant_s = NO_REQ;
            busy_s  = 1'b0;
            count_s = ZERO_CNT;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r      <= IDLE;
         grant_r      <= NO_REQ;
         done_r       <= NO_REQ;
         busy_r       <= 1'b0;
         owner_r      <= ZERO_IDX;
         last_owner_r <= LAST_IDX;
         count_r      <= ZERO_CNT;
      end else begin
         state_r      <= state_s;
         grant_r      <= grant_s;
         done_r       <= done_s;
         busy_r       <= busy_s;
         owner_r      <= owner_s;
         last_owner_r <= last_owner_s;
         count_r      <= count_s;
      end
   end

   assign bus.grant = grant_r;
   assign bus.done  = done_r;
   assign bus.busy  = busy_r;
   assign bus.owner = owner_r;
   assign bus.count = count_r;
endmodule

// File: tb/tb_countdown_scheduler.sv
// Scenario-per-task bench for countdown_scheduler; expected grant owners and
// done cycles are queued when stimulus is applied and popped on DUT output.
module tb_countdown_scheduler;
   localparam int DATA_WIDTH = 8;
   localparam int NUM_REQ    = 4;
   localparam int IDX_WIDTH  = 2;

   logic clock = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   int   exp_q[$];

   countdown_scheduler_if #(.DATA_WIDTH(DATA_WIDTH), .NUM_REQ(NUM_REQ), .IDX_WIDTH(IDX_WIDTH)) bus ();

   countdown_scheduler #(.DATA_WIDTH(DATA_WIDTH), .NUM_REQ(NUM_REQ), .IDX_WIDTH(IDX_WIDTH)) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clock = ~clock;

   // Outputs are sampled and inputs driven 1 time unit after each rising edge.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic set_len(input int idx, input logic [DATA_WIDTH-1:0] len);
      bus.req_len[idx*DATA_WIDTH +: DATA_WIDTH] = len;
   endtask

   task automatic go_idle();
      bus.req  = 4'b0000;
      bus.tick = 1'b0;
      repeat (3) step();
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      step();
      step();
      reset    = 1'b1;
      bus.req  = 4'b0000;
      bus.tick = 1'b0;
   endtask

   task automatic test_reset();
      logic [18:0] obs;
      #3;
      obs = {bus.grant, bus.done, bus.busy, bus.count, bus.owner};
      checks++;
      if (obs !== 19'd0) begin
         errors++;
         $display("FAIL reset_time0 got %h want 0", obs);
      end
      step();
      reset    = 1'b1;
      bus.req  = 4'b0001;
      set_len(0, 8'd5);
      bus.tick = 1'b0;
      step();
      checks++;
      if (bus.grant !== 4'b0001 || bus.busy !== 1'b1 || bus.count !== 8'd5) begin
         errors++;
         $display("FAIL reset_pre_grant got grant=%b busy=%b count=%0d want 0001 1 5", bus.grant, bus.busy, bus.count);
      end
      #2;
      reset = 1'b0;
      #1;
      obs = {bus.grant, bus.done, bus.busy, bus.count, bus.owner};
      checks++;
      if (obs !== 19'd0) begin
         errors++;
         $display("FAIL reset_mid_run got %h want 0", obs);
      end
      step();
      reset = 1'b1;
      step();
      checks++;
      if (bus.grant !== 4'b0001 || bus.owner !== 2'd0 || bus.done !== 4'b0000 || bus.count !== 8'd5) begin
         errors++;
         $display("FAIL reset_regrant got grant=%b owner=%0d done=%b count=%0d want 0001 0 0000 5",
                  bus.grant, bus.owner, bus.done, bus.count);
      end
      go_idle();
   endtask

   task automatic test_single();
      logic [3:0] exp_grant [5] = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
      logic       exp_busy  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      logic [7:0] exp_count [5] = '{8'd3, 8'd2, 8'd1, 8'd0, 8'd0};
      int want;
      bus.req  = 4'b0010;
      set_len(1, 8'd3);
      bus.tick = 1'b1;
      exp_q.push_back(4);
      for (int c = 1; c <= 5; c++) begin
         step();
         checks++;
         if (bus.grant !== exp_grant[c-1] || bus.busy !== exp_busy[c-1] || bus.count !== exp_count[c-1]) begin
            errors++;
            $display("FAIL single_c%0d got grant=%b busy=%b count=%0d want %b %b %0d", c,
                     bus.grant, bus.busy, bus.count, exp_grant[c-1], exp_busy[c-1], exp_count[c-1]);
         end
         if (bus.done !== 4'b0000) begin
            want = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
            checks++;
            if (c !== want || bus.done !== 4'b0010) begin
               errors++;
               $display("FAIL single_done got cycle=%0d done=%b want %0d 0010", c, bus.done, want);
            end
            bus.req = 4'b0000;
         end
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL single_no_done got pending=%0d want 0", exp_q.size());
         exp_q.delete();
      end
      go_idle();
   endtask

   task automatic test_round_robin();
      logic [3:0] prev_grant;
      logic [3:0] exp_vec;
      int want;
      apply_reset();
      for (int i = 0; i < NUM_REQ; i++) set_len(i, 8'd2);
      bus.tick = 1'b1;
      for (int ph = 0; ph < 2; ph++) begin
         if (ph == 0) begin
            bus.req = 4'b1111;
            exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
         end else begin
            bus.req = 4'b1001;
            exp_q.push_back(0); exp_q.push_back(3);
         end
         prev_grant = 4'b0000;
         for (int c = 0; c < 60 && (exp_q.size() != 0 || bus.req != 4'b0000); c++) begin
            step();
            if (bus.grant != 4'b0000 && prev_grant == 4'b0000) begin
               want    = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
               exp_vec = 4'b0001 << want;
               checks++;
               if (int'(bus.owner) !== want || bus.grant !== exp_vec) begin
                  errors++;
                  $display("FAIL rr_order_ph%0d got owner=%0d grant=%b want %0d %b", ph, bus.owner, bus.grant, want, exp_vec);
               end
            end
            if (bus.done != 4'b0000) begin
               checks++;
               if (bus.done !== prev_grant) begin
                  errors++;
                  $display("FAIL rr_done_ph%0d got %b want %b", ph, bus.done, prev_grant);
               end
               bus.req = bus.req & ~bus.done;
            end
            prev_grant = bus.grant;
         end
         checks++;
         if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rr_timeout_ph%0d got pending=%0d want 0", ph, exp_q.size());
            exp_q.delete();
         end
      end
      go_idle();
   endtask

   task automatic test_zero_len();
      bus.req  = 4'b0100;
      set_len(2, 8'd0);
      bus.tick = 1'b1;
      step();
      checks++;
      if (bus.done !== 4'b0100 || bus.busy !== 1'b0 || bus.count !== 8'd0 || bus.grant !== 4'b0000 || bus.owner !== 2'd2) begin
         errors++;
         $display("FAIL zero_len_done got done=%b busy=%b count=%0d grant=%b owner=%0d want 0100 0 0 0000 2",
                  bus.done, bus.busy, bus.count, bus.grant, bus.owner);
      end
      bus.req = 4'b0000;
      for (int c = 2; c <= 3; c++) begin
         step();
         checks++;
         if (bus.done !== 4'b0000 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_after_c%0d got done=%b busy=%b want 0000 0", c, bus.done, bus.busy);
         end
      end
      go_idle();
   endtask

   task automatic test_tick_gaps();
      logic       pat       [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      logic [7:0] exp_count [7] = '{8'd4, 8'd3, 8'd3, 8'd2, 8'd1, 8'd1, 8'd0};
      int want;
      bus.req  = 4'b0001;
      set_len(0, 8'd4);
      bus.tick = 1'b0;
      exp_q.push_back(7);
      for (int c = 1; c <= 10; c++) begin
         step();
         if (c <= 7) begin
            checks++;
            if (bus.count !== exp_count[c-1]) begin
               errors++;
               $display("FAIL gaps_count_c%0d got %0d want %0d", c, bus.count, exp_count[c-1]);
            end
         end
         bus.tick = (c <= 6) ? pat[c-1] : 1'b0;
         if (bus.done !== 4'b0000) begin
            want = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
            checks++;
            if (c !== want || bus.done !== 4'b0001) begin
               errors++;
               $display("FAIL gaps_done got cycle=%0d done=%b want %0d 0001", c, bus.done, want);
            end
            bus.req = 4'b0000;
         end
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL gaps_no_done got pending=%0d want 0", exp_q.size());
         exp_q.delete();
      end
      go_idle();
   endtask

   task automatic test_abort();
      logic [3:0] prev_grant;
      logic [3:0] exp_vec;
      int want;
      int abort_c;
      abort_c    = -10;
      prev_grant = 4'b0000;
      set_len(2, 8'd4);
      set_len(0, 8'd3);
      bus.req  = 4'b0101;
      bus.tick = 1'b1;
      exp_q.push_back(2);
      exp_q.push_back(0);
      for (int c = 1; c <= 12; c++) begin
         step();
         checks++;
         if (bus.done !== 4'b0000) begin
            errors++;
            $display("FAIL abort_done_c%0d got %b want 0000", c, bus.done);
         end
         if (c == abort_c + 1) begin
            checks++;
            if (bus.grant !== 4'b0000 || bus.busy !== 1'b0 || bus.count !== 8'd0) begin
               errors++;
               $display("FAIL abort_clear got grant=%b busy=%b count=%0d want 0000 0 0", bus.grant, bus.busy, bus.count);
            end
         end
         if (bus.grant != 4'b0000 && prev_grant == 4'b0000) begin
            want    = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
            exp_vec = 4'b0001 << want;
            checks++;
            if (int'(bus.owner) !== want || bus.grant !== exp_vec) begin
               errors++;
               $display("FAIL abort_grant got owner=%0d grant=%b want %0d %b", bus.owner, bus.grant, want, exp_vec);
            end
         end
         if (bus.grant == 4'b0100 && bus.count == 8'd2) begin
            bus.req[2] = 1'b0;
            abort_c    = c;
         end
         if (bus.grant == 4'b0001) bus.req[0] = 1'b0;
         bus.tick   = (c == 2) ? 1'b0 : 1'b1;
         prev_grant = bus.grant;
      end
      checks++;
      if (exp_q.size() != 0 || abort_c < 0) begin
         errors++;
         $display("FAIL abort_sequence got pending=%0d abort_cycle=%0d want 0 >=1", exp_q.size(), abort_c);
         exp_q.delete();
      end
      go_idle();
   endtask

   task automatic test_abort_final_tick();
      bus.req  = 4'b0010;
      set_len(1, 8'd1);
      bus.tick = 1'b1;
      step();
      checks++;
      if (bus.grant !== 4'b0010 || bus.count !== 8'd1) begin
         errors++;
         $display("FAIL final_setup got grant=%b count=%0d want 0010 1", bus.grant, bus.count);
      end
      bus.req = 4'b0000;
      step();
      checks++;
      if (bus.grant !== 4'b0000 || bus.busy !== 1'b0 || bus.done !== 4'b0000 || bus.count !== 8'd0) begin
         errors++;
         $display("FAIL final_abort got grant=%b busy=%b done=%b count=%0d want 0000 0 0000 0",
                  bus.grant, bus.busy, bus.done, bus.count);
      end
      for (int c = 3; c <= 4; c++) begin
         step();
         checks++;
         if (bus.done !== 4'b0000) begin
            errors++;
            $display("FAIL final_no_done_c%0d got %b want 0000", c, bus.done);
         end
      end
   endtask

   initial begin
      reset       = 1'b0;
      bus.req     = 4'b0000;
      bus.req_len = 32'd0;
      bus.tick    = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_zero_len();
      test_tick_gaps();
      test_abort();
      test_abort_final_tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
